mem_port_arbiter: RTL and testbench

Two-client arbiter that shares one downstream memory port between instruction fetch (client 0) and the load/store unit (client 1). It sits between the core's two memory clients and a single unified memory. Requests are granted round-robin. Each grant's client ID is pushed into an in-order ID FIFO, and responses are steered back to the owning client from the FIFO head.

---
 rtl/mem_arb_pkg.sv | 32 +++
 rtl/mem_arb_id_fifo.sv | 63 ++++++
 rtl/mem_port_arbiter.sv | 92 +++++++++
 tb/tb_mem_port_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-client memory port arbiter: request/response
// messages and the client ID encoding.
package mem_arb_pkg;

  localparam int unsigned P_OPAQ_BITS = 8;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_op_e;

  typedef struct packed {
    mem_op_e                op;
    logic [P_OPAQ_BITS-1:0] opaque;
    logic [31:0]            addr;
    logic [1:0]             len;
    logic [31:0]            data;
  } mem_req_t;

  typedef struct packed {
    mem_op_e                op;
    logic [P_OPAQ_BITS-1:0] opaque;
    logic [1:0]             len;
    logic [31:0]            data;
  } mem_resp_t;

  typedef logic cli_id_t;

  localparam cli_id_t CLI_FETCH = 1'b0;
  localparam cli_id_t CLI_LSU   = 1'b1;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO of client IDs for outstanding memory requests; the head
// names the client that owns the next response from memory.
module mem_arb_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // A push while full is dropped here as well, so the count can never
  // exceed the depth even if the producer misbehaves.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values of its inputs regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; count_q alone says which entries
  // are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one in-order memory port between instruction
// fetch and the LSU, with responses steered back by an ID FIFO.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned p_max_inflight = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] cli_req_val_i,
  output logic [1:0] cli_req_rdy_o,
  input  mem_req_t   cli_req_msg_i [2],
  output logic [1:0] cli_resp_val_o,
  input  logic [1:0] cli_resp_rdy_i,
  output mem_resp_t  cli_resp_msg_o [2],
  output logic       mem_req_val_o,
  input  logic       mem_req_rdy_i,
  output mem_req_t   mem_req_msg_o,
  input  logic       mem_resp_val_i,
  output logic       mem_resp_rdy_o,
  input  mem_resp_t  mem_resp_msg_i
);

  cli_id_t                         prio_q, prio_d;
  cli_id_t                         winner, head;
  logic [1:0]                      cand;
  logic                            req_fire, resp_fire;
  logic                            fifo_full, fifo_empty;
  logic [$clog2(p_max_inflight):0] fifo_count;

  // NOTE: every output of this block gets a default before any branch so
  // no path leaves a variable unassigned and infers a latch.
  always_comb begin
    cand          = cli_req_val_i & {2{!fifo_full}};
    winner        = CLI_FETCH;
    if (cand[CLI_LSU] && (!cand[CLI_FETCH] || prio_q == CLI_LSU)) winner = CLI_LSU;
    mem_req_val_o = |cand;
    mem_req_msg_o = cli_req_msg_i[winner];
    req_fire      = mem_req_val_o && mem_req_rdy_i;
    cli_req_rdy_o = '0;
    cli_req_rdy_o[winner] = req_fire;
    prio_d        = req_fire ? ~winner : prio_q;

    cli_resp_val_o = '0;
    cli_resp_val_o[head] = mem_resp_val_i && !fifo_empty;
    mem_resp_rdy_o = !fifo_empty && cli_resp_rdy_i[head];
    resp_fire      = mem_resp_val_i && mem_resp_rdy_o;
    for (int i = 0; i < 2; i++) cli_resp_msg_o[i] = mem_resp_msg_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= CLI_FETCH;
    else        prio_q <= prio_d;
  end

  mem_arb_id_fifo #(
    .DEPTH (p_max_inflight),
    .WIDTH (1)
  ) u_id_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (req_fire),
    .push_data_i (winner),
    .pop_i       (resp_fire),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head),
    .count_o     (fifo_count)
  );

`ifndef SYNTHESIS
  // A response with nothing outstanding means memory and arbiter disagree.
  int unsigned proto_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             proto_err_cnt <= 0;
    else if (mem_resp_val_i && fifo_empty) proto_err_cnt <= proto_err_cnt + 1;
  end

  always @(posedge clk) begin
    if (rst_n)
      assert (!(mem_resp_val_i && fifo_empty))
        else $warning("mem_port_arbiter: response with no outstanding request");
  end

  function automatic string trace();
    return $sformatf("grant=%0b/%0d occ=%0d/%0d resp=%0b/%0d",
                     req_fire, winner, fifo_count, p_max_inflight, resp_fire, head);
  endfunction
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, alternation, full, wrap,
// backpressure, protocol error and asynchronous reset.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] cli_req_val, cli_req_rdy, cli_resp_val, cli_resp_rdy;
  mem_req_t   cli_req_msg [2];
  mem_resp_t  cli_resp_msg [2];
  logic       mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;
  mem_req_t   mem_req_msg;
  mem_resp_t  mem_resp_msg;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] ADDR0 = 32'h100;
  localparam logic [31:0] ADDR1 = 32'h200;
  localparam logic [7:0]  OPQ0  = 8'h11;
  localparam logic [7:0]  OPQ1  = 8'h22;

  always #5 clk = ~clk;

  mem_port_arbiter #(.p_max_inflight(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cli_req_val_i  (cli_req_val),
    .cli_req_rdy_o  (cli_req_rdy),
    .cli_req_msg_i  (cli_req_msg),
    .cli_resp_val_o (cli_resp_val),
    .cli_resp_rdy_i (cli_resp_rdy),
    .cli_resp_msg_o (cli_resp_msg),
    .mem_req_val_o  (mem_req_val),
    .mem_req_rdy_i  (mem_req_rdy),
    .mem_req_msg_o  (mem_req_msg),
    .mem_resp_val_i (mem_resp_val),
    .mem_resp_rdy_o (mem_resp_rdy),
    .mem_resp_msg_i (mem_resp_msg)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_resp(input logic val, input logic [31:0] data);
    mem_resp_val = val;
    mem_resp_msg = '{op: MEM_READ, opaque: 8'h5A, len: 2'd2, data: data};
  endtask

  function automatic logic [1:0] onehot(input int id);
    logic [1:0] v;
    v = 2'b01 << id;
    return v;
  endfunction

  task automatic check_grant(input string tag, input int id);
    check({tag, "_req_rdy"}, cli_req_rdy, onehot(id));
    check({tag, "_addr"},    mem_req_msg.addr, (id == 1) ? ADDR1 : ADDR0);
    check({tag, "_opaque"},  mem_req_msg.opaque, (id == 1) ? OPQ1 : OPQ0);
  endtask

  task automatic check_resp(input string tag, input int id, input logic [31:0] data);
    check({tag, "_resp_val"},  cli_resp_val, onehot(id));
    check({tag, "_resp_data"}, cli_resp_msg[id].data, data);
  endtask

  // Mixed push/pop rows: client valids, expected grant, expected response owner.
  localparam int N_MIX = 8;
  logic [1:0] mix_val   [N_MIX] = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11};
  int         mix_grant [N_MIX] = '{0, 1, 0, 1, 1, 0, 0, 1};
  int         mix_head  [N_MIX] = '{1, 0, 0, 1, 0, 1, 1, 0};

  initial begin
    rst_n        = 1'b0;
    cli_req_val  = 2'b11;
    cli_resp_rdy = 2'b11;
    mem_req_rdy  = 1'b1;
    cli_req_msg[0] = '{op: MEM_READ,  opaque: OPQ0, addr: ADDR0, len: 2'd3, data: 32'h0};
    cli_req_msg[1] = '{op: MEM_WRITE, opaque: OPQ1, addr: ADDR1, len: 2'd2, data: 32'hCAFE_0001};
    drive_resp(1'b0, 32'h0);

    // Reset held across two edges with both clients requesting.
    step();
    step();
    check("rst_count", dut.u_id_fifo.count_q, 0);
    check("rst_wr_ptr", dut.u_id_fifo.wr_ptr_q, 0);
    check("rst_prio", dut.prio_q, 0);
    check("rst_resp_val", cli_resp_val, 2'b00);
    check("rst_mem_resp_rdy", mem_resp_rdy, 1'b0);
    check("rst_mem_req_val", mem_req_val, 1'b1);
    #2 rst_n = 1'b1;
    #1;

    // Contention: six alternating grants, each answered the following cycle.
    for (int c = 0; c <= 6; c++) begin
      cli_req_val = (c < 6) ? 2'b11 : 2'b00;
      drive_resp(c > 0, 32'hA000 + 32'(c));
      #2;
      if (c < 6) check_grant($sformatf("cont%0d", c), c % 2);
      if (c > 0) check_resp($sformatf("cont%0d", c), (c - 1) % 2, 32'hA000 + 32'(c));
      step();
    end
    drive_resp(1'b0, 32'h0);
    check("cont_count", dut.u_id_fifo.count_q, 0);

    // Fill the FIFO with no responses returning.
    cli_req_val = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #2;
      check_grant($sformatf("fill%0d", k), k % 2);
      step();
    end
    #2;
    check("full_count", dut.u_id_fifo.count_q, 4);
    check("full_req_val", mem_req_val, 1'b0);
    check("full_req_rdy", cli_req_rdy, 2'b00);
    drive_resp(1'b1, 32'hB000);
    #1;
    check("full_pop_req_val", mem_req_val, 1'b0);
    check_resp("full_pop", 0, 32'hB000);
    step();
    drive_resp(1'b0, 32'h0);
    #2;
    check("refill_count", dut.u_id_fifo.count_q, 3);
    check_grant("refill", 0);
    step();
    check("refill_full", dut.u_id_fifo.count_q, 4);

    // Backpressure: head belongs to client 1, which is not ready.
    cli_req_val  = 2'b00;
    cli_resp_rdy = 2'b01;
    drive_resp(1'b1, 32'hC000);
    #2;
    check("bp_mem_resp_rdy", mem_resp_rdy, 1'b0);
    check("bp_resp_val", cli_resp_val, 2'b10);
    step();
    check("bp_count_held", dut.u_id_fifo.count_q, 4);
    cli_resp_rdy = 2'b11;
    for (int k = 0; k < 4; k++) begin
      drive_resp(1'b1, 32'hC100 + 32'(k));
      #2;
      check_resp($sformatf("drain%0d", k), (k % 2 == 0) ? 1 : 0, 32'hC100 + 32'(k));
      step();
    end
    drive_resp(1'b0, 32'h0);
    check("drain_count", dut.u_id_fifo.count_q, 0);
    check("drain_rd_ptr", dut.u_id_fifo.rd_ptr_q, 3);

    // Prime two entries, then push and pop together every cycle.
    cli_req_val = 2'b11;
    #2;
    check_grant("prime0", 1);
    step();
    check("prime_wr_wrap", dut.u_id_fifo.wr_ptr_q, 0);
    #2;
    check_grant("prime1", 0);
    step();
    for (int r = 0; r < N_MIX; r++) begin
      cli_req_val = mix_val[r];
      drive_resp(1'b1, 32'hD000 + 32'(r));
      #2;
      check_grant($sformatf("mix%0d", r), mix_grant[r]);
      check_resp($sformatf("mix%0d", r), mix_head[r], 32'hD000 + 32'(r));
      step();
      check($sformatf("mix%0d_count", r), dut.u_id_fifo.count_q, 2);
      if (r == 0) check("mix_rd_wrap", dut.u_id_fifo.rd_ptr_q, 0);
    end
    cli_req_val = 2'b00;
    for (int k = 0; k < 2; k++) begin
      drive_resp(1'b1, 32'hD100 + 32'(k));
      #2;
      check_resp($sformatf("mixdrain%0d", k), k, 32'hD100 + 32'(k));
      step();
    end
    drive_resp(1'b0, 32'h0);
    check("mix_final_count", dut.u_id_fifo.count_q, 0);

    // Response with nothing outstanding.
    drive_resp(1'b1, 32'hE000);
    #2;
    check("err_mem_resp_rdy", mem_resp_rdy, 1'b0);
    check("err_resp_val", cli_resp_val, 2'b00);
    step();
    drive_resp(1'b0, 32'h0);
    check("err_flagged", dut.proto_err_cnt, 1);
    check("err_count", dut.u_id_fifo.count_q, 0);

    // Three in flight, then reset between edges.
    cli_req_val = 2'b01;
    step();
    step();
    step();
    cli_req_val = 2'b00;
    check("pre_rst_count", dut.u_id_fifo.count_q, 3);
    check("pre_rst_prio", dut.prio_q, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_count", dut.u_id_fifo.count_q, 0);
    check("async_rst_prio", dut.prio_q, 0);
    check("async_rst_mem_resp_rdy", mem_resp_rdy, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
